serial_pattern_tx: RTL and testbench
====================================

# serial_pattern_tx

Serial pattern transmitter: accepts a WIDTH-bit word and a repeat count, then drives the word MSB-first onto a one-bit serial line, one bit per clock. The word repeats back-to-back the requested number of times. It is the source end of the single-bit `signal` line consumed by the team's serial run detectors, and it provides stimulus and loopback traffic for them on the board. A registered `run3` flag marks every transmitted bit that completes a run of three equal bits, so detector outputs can be checked against the transmitter.

## Interface
- WIDTH, 8, bits per word (≥ 3)
- REP_W, 4, width of repeat count
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  request; sampled only while ready=1
- data  in  WIDTH  word to send, sampled with start
- reps  in  REP_W  number of word repetitions, sampled with start (0 = send nothing)
- ready  out  1  block idle, start will be accepted
- signal  out  1  serial data bit (MSB of word first)
- sig_valid  out  1  signal carries a transmitted bit this cycle
- done  out  1  one-cycle pulse after the last bit of a request
- run3  out  1  current bit equals the previous two transmitted bits of this request

## Operation
- Reset values (rst=1 at a rising edge): ready=1, signal=0, sig_valid=0, done=0, run3=0, FSM=IDLE, run history cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - ready=1, sig_valid=0, signal=0.
  - start=1 with reps≠0: latch data into the word register and the shift register, load the repeat counter with reps, clear the bit counter and run history, go to SHIFT.
  - start=1 with reps=0: go directly to DONE. No bits are sent.
- SHIFT
  - ready=0.
  - Each cycle: signal = shift-register MSB, sig_valid=1, shift left, bit counter +1.
  - At bit WIDTH-1 with repeat counter > 1: reload the shift register from the word register, decrement the repeat counter, clear the bit counter. No idle gap between repetitions.
  - At bit WIDTH-1 with repeat counter = 1: go to DONE.
- DONE: done=1, ready=0, sig_valid=0, signal=0 for exactly one cycle, then go to IDLE.
- start while ready=0 is ignored. data and reps may change freely after acceptance.
- run3 logic
  - Keep a 2-bit history of the last bits sent in the current request, plus a 2-bit fill count saturating at 2.
  - run3=1 in a sig_valid cycle when the fill count is 2 and the current bit equals both history bits.
  - The history spans repetition boundaries.
  - The history is cleared on accept and on reset.
  - run3=0 whenever sig_valid=0.
- Repeat counter is REP_W bits, so the maximum transmission is WIDTH×(2^REP_W−1) bits. No wrap-around is possible.
- Reset mid-operation: the transmission aborts at that edge, no done pulse, all outputs take their reset values.

## Timing
- All outputs are registered.
- start accepted at edge 0 (the first rising edge with start=1 and ready=1).
- First bit: sig_valid=1 in cycle 1, which is the cycle after edge 0.
- Bit k of the request, for k = 1 … WIDTH×reps, appears in cycle k, contiguously.
- done=1 in cycle WIDTH×reps+1.
- ready=1 again in cycle WIDTH×reps+2. A start sampled in that cycle puts its first bit in the following cycle.
- reps=0: done in cycle 1, ready in cycle 2.
- run3 is aligned with the bit that completes the run (same cycle as that bit's sig_valid).

## Test plan
- Reset: hold rst=1 for 2 cycles mid-idle → ready=1, signal=0, sig_valid=0, done=0, run3=0.
- WIDTH=8, data=8'hA5, reps=1, start at cycle 0 → signal in cycles 1–8 = 1,0,1,0,0,1,0,1 with sig_valid=1; run3 never set; done in cycle 9; ready in cycle 10.
- data=8'hE3, reps=2 → 16 contiguous bits 11100011 11100011; run3=1 exactly in cycles 3, 6, 9, 10, 11, 14; done in cycle 17.
- reps=0 → sig_valid never set; done in cycle 1; ready in cycle 2.
- data=8'hFF, reps=3; pulse start again in cycle 2 with data=8'h00, which is ignored; rst=1 in cycle 4 → from cycle 5: ready=1, sig_valid=0, run3=0; no done pulse.
- Back-to-back: data=8'hFF, reps=1, then a second start with 8'hFF asserted in cycle 10 → second frame bits in cycles 11–18; run3 set in cycles 3–8 and 13–18 only, showing the history was cleared between requests.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a word MSB-first, repeated reps times,
// and flags every transmitted bit that completes a run of three equal bits.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [REP_W-1:0] reps,
  output logic             ready,
  output logic             signal,
  output logic             sig_valid,
  output logic             done,
  output logic             run3
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] word, word_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [REP_W-1:0] rep, rep_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [1:0]       hist, hist_n;
  logic [1:0]       fill, fill_n;
  logic [1:0]       hist_c, fill_c;
  logic             ready_n, signal_n, valid_n;
  logic             done_n, run3_n;
  logic             emit, bit_o;

  always_comb begin
    state_n  = state;
    word_n   = word;
    sh_n     = sh;
    rep_n    = rep;
    cnt_n    = cnt;
    hist_n   = hist;
    fill_n   = fill;
    hist_c   = hist;
    fill_c   = fill;
    ready_n  = 1'b0;
    signal_n = 1'b0;
    valid_n  = 1'b0;
    done_n   = 1'b0;
    run3_n   = 1'b0;
    emit     = 1'b0;
    bit_o    = 1'b0;
    unique case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (start) begin
          ready_n = 1'b0;
          if (reps != '0) begin
            state_n = SHIFT;
            word_n  = data;
            sh_n    = {data[WIDTH-2:0], 1'b0};
            rep_n   = reps;
            cnt_n   = CW'(1);
            hist_c  = 2'b00;
            fill_c  = 2'd0;
            emit    = 1'b1;
            bit_o   = data[WIDTH-1];
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH)) begin
          // word boundary: reload for the next repetition or finish
          if (rep > REP_W'(1)) begin
            emit  = 1'b1;
            bit_o = word[WIDTH-1];
            sh_n  = {word[WIDTH-2:0], 1'b0};
            cnt_n = CW'(1);
            rep_n = rep - REP_W'(1);
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end else begin
          emit  = 1'b1;
          bit_o = sh[WIDTH-1];
          sh_n  = {sh[WIDTH-2:0], 1'b0};
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (emit) begin
      valid_n  = 1'b1;
      signal_n = bit_o;
      run3_n   = (fill_c == 2'd2) && (hist_c[0] == bit_o)
                 && (hist_c[1] == bit_o);
      hist_n   = {hist_c[0], bit_o};
      fill_n   = (fill_c == 2'd2) ? 2'd2 : fill_c + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word      <= '0;
      sh        <= '0;
      rep       <= '0;
      cnt       <= '0;
      hist      <= 2'b00;
      fill      <= 2'd0;
      ready     <= 1'b1;
      signal    <= 1'b0;
      sig_valid <= 1'b0;
      done      <= 1'b0;
      run3      <= 1'b0;
    end else begin
      state     <= state_n;
      word      <= word_n;
      sh        <= sh_n;
      rep       <= rep_n;
      cnt       <= cnt_n;
      hist      <= hist_n;
      fill      <= fill_n;
      ready     <= ready_n;
      signal    <= signal_n;
      sig_valid <= valid_n;
      done      <= done_n;
      run3      <= run3_n;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: model-driven scoreboard with
// directed and random requests.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic [3:0] reps;
  logic       ready, signal, sig_valid, done, run3;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    bit d;
    bit sig;
    bit r3;
  } exp_t;

  exp_t q[$];

  serial_pattern_tx #(.WIDTH(8), .REP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data), .reps(reps),
    .ready(ready), .signal(signal), .sig_valid(sig_valid),
    .done(done), .run3(run3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  // expected stream: word bits repeated, run3 from three equal bits
  task automatic model(input logic [7:0] d, input int r);
    bit b[$];
    exp_t e;
    for (int rr = 0; rr < r; rr++)
      for (int i = 7; i >= 0; i--) b.push_back(d[i]);
    for (int k = 0; k < b.size(); k++) begin
      e.d   = 1'b0;
      e.sig = b[k];
      e.r3  = (k >= 2) && (b[k] == b[k-1]) && (b[k] == b[k-2]);
      q.push_back(e);
    end
    e.d = 1'b1; e.sig = 1'b0; e.r3 = 1'b0;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!sig_valid && (signal || run3))
      chk("idle_quiet", {signal, run3}, 0);
    if (sig_valid || done) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {sig_valid, done}, 0);
      end else begin
        e = q.pop_front();
        chk("done", done, e.d);
        chk("signal", signal, e.sig);
        chk("run3", run3, e.r3);
      end
    end
  end

  // call at a negedge; returns at the negedge where ready is back
  task automatic send(input logic [7:0] d, input int r);
    int n, cyc, dcyc, nsv, lastsv, g;
    g = 0;
    while (!ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("ready_before_send", ready, 1);
    n = 8 * r;
    start = 1'b1; data = d; reps = 4'(r);
    model(d, r);
    @(posedge clk);
    #1;
    start = 1'b0; data = 8'($urandom); reps = 4'($urandom);
    cyc = 0; dcyc = -1; nsv = 0; lastsv = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (done) dcyc = cyc;
      if (sig_valid) begin
        nsv++;
        lastsv = cyc;
      end
    end while (!ready && cyc < 300);
    chk("done_cycle", dcyc, n + 1);
    chk("ready_cycle", cyc, n + 2);
    chk("bit_count", nsv, n);
    chk("last_bit_cycle", lastsv, n);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", ready, 1);
    chk("rst_signal", signal, 0);
    chk("rst_sig_valid", sig_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_run3", run3, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data = '0; reps = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();

    send(8'hA5, 1);
    send(8'hE3, 2);
    send(8'h00, 0);

    // idle reset held two cycles
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();

    // back-to-back: second start lands in the ready cycle
    send(8'hFF, 1);
    send(8'hFF, 1);

    // reset mid-transmission with an ignored start in cycle 2
    start = 1'b1; data = 8'hFF; reps = 4'd3;
    model(8'hFF, 3);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1; data = 8'h00; reps = 4'd1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("bits_before_abort", q.size(), 21);
    q.delete();
    @(negedge clk);
    chk_reset_vals();
    repeat (30) @(negedge clk);
    chk("no_done_after_abort", q.size(), 0);

    for (int i = 0; i < 25; i++) begin
      int r;
      r = (i % 8 == 7) ? 15 : int'($urandom_range(0, 3));
      send(8'($urandom), r);
    end
    send(8'h0F, 15);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
